// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the forwarding/hazard control slice: forward selects,
// branch condition codes and the in-flight pipeline slot record.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_ALU = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
  } pipe_slot_t;

  // x0 is hardwired zero, so it never produces a hazard.
  function automatic logic slot_hit(pipe_slot_t s, logic use_src, logic [4:0] src);
    return s.valid & s.we & (s.rd != 5'd0) & use_src & (s.rd == src);
  endfunction

  // The youngest producer wins: EX before M.
  function automatic fwd_sel_e fwd_sel(pipe_slot_t ex, pipe_slot_t m,
                                       logic use_src, logic [4:0] src);
    if (slot_hit(ex, use_src, src))     return FWD_ALU;
    else if (slot_hit(m, use_src, src)) return FWD_WB;
    else                                return FWD_REG;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from the compare flags; purely combinational.
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = br_eq;
      F3_BNE:           taken = ~br_eq;
      F3_BLT, F3_BLTU:  taken = br_lt;
      F3_BGE, F3_BGEU:  taken = ~br_lt;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use / branch-redirect control for the stage ahead of the ALU.
// Optional HAZARD_PERF_CNT_EN adds stall and flush event counters.
module fwd_hazard_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       iss_valid_i,
  output logic       iss_ready_o,
  input  logic [4:0] iss_rs1_i,
  input  logic [4:0] iss_rs2_i,
  input  logic       iss_use_rs1_i,
  input  logic       iss_use_rs2_i,
  input  logic [4:0] iss_rd_i,
  input  logic       iss_we_i,
  input  logic       iss_load_i,
  input  logic       iss_branch_i,
  input  logic       iss_jump_i,
  input  logic [2:0] iss_funct3_i,
  input  logic       iss_a_pc_i,
  input  logic       iss_b_imm_i,
  input  logic       BrEq_i,
  input  logic       BrLT_i,
  output logic [1:0] A1_sel_o,
  output logic [1:0] B1_sel_o,
  output logic       A2_sel_o,
  output logic       B2_sel_o,
  output logic       BrUn_o,
  output logic       ex_valid_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic       redirect_o
);

  pipe_slot_t ex_q, m_q, iss_slot;
  fwd_sel_e   a1_sel_q, b1_sel_q;
  logic       a2_sel_q, b2_sel_q, br_un_q;
  logic       ex_taken, load_use, stall, accept;

  branch_cond u_branch_cond (
    .funct3 (ex_q.funct3),
    .br_eq  (BrEq_i),
    .br_lt  (BrLT_i),
    .taken  (ex_taken)
  );

  always_comb begin
    iss_slot        = '0;
    iss_slot.valid  = 1'b1;
    iss_slot.rd     = iss_rd_i;
    iss_slot.we     = iss_we_i;
    iss_slot.load   = iss_load_i;
    iss_slot.branch = iss_branch_i;
    iss_slot.jump   = iss_jump_i;
    iss_slot.funct3 = iss_funct3_i;
  end

  assign redirect_o  = ex_q.valid & (ex_q.jump | (ex_q.branch & ex_taken));
  assign load_use    = iss_valid_i & ex_q.load &
                       (slot_hit(ex_q, iss_use_rs1_i, iss_rs1_i) |
                        slot_hit(ex_q, iss_use_rs2_i, iss_rs2_i));
  // A redirect flushes the offered instruction anyway, so it overrides the stall.
  assign stall       = load_use & ~redirect_o;
  assign iss_ready_o = ~stall;
  assign accept      = iss_valid_i & ~stall & ~redirect_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      m_q      <= '0;
      a1_sel_q <= FWD_REG;
      b1_sel_q <= FWD_REG;
      a2_sel_q <= 1'b0;
      b2_sel_q <= 1'b0;
      br_un_q  <= 1'b0;
    end else begin
      m_q <= ex_q;
      if (accept) begin
        ex_q     <= iss_slot;
        a1_sel_q <= fwd_sel(ex_q, m_q, iss_use_rs1_i, iss_rs1_i);
        b1_sel_q <= fwd_sel(ex_q, m_q, iss_use_rs2_i, iss_rs2_i);
        a2_sel_q <= iss_a_pc_i;
        b2_sel_q <= iss_b_imm_i;
        br_un_q  <= iss_funct3_i[1] & iss_branch_i;
      end else begin
        ex_q     <= '0;
        a1_sel_q <= FWD_REG;
        b1_sel_q <= FWD_REG;
        a2_sel_q <= 1'b0;
        b2_sel_q <= 1'b0;
        br_un_q  <= 1'b0;
      end
    end
  end

  assign A1_sel_o   = a1_sel_q;
  assign B1_sel_o   = b1_sel_q;
  assign A2_sel_o   = a2_sel_q;
  assign B2_sel_o   = b2_sel_q;
  assign BrUn_o     = br_un_q;
  assign ex_valid_o = ex_q.valid;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall)      stall_cnt_o <= stall_cnt_o + 32'd1;
      if (redirect_o) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl (counter checks only when
// HAZARD_PERF_CNT_EN is defined).
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       iss_valid_i, iss_ready_o;
  logic [4:0] iss_rs1_i, iss_rs2_i, iss_rd_i;
  logic       iss_use_rs1_i, iss_use_rs2_i, iss_we_i, iss_load_i;
  logic       iss_branch_i, iss_jump_i, iss_a_pc_i, iss_b_imm_i;
  logic [2:0] iss_funct3_i;
  logic       BrEq_i, BrLT_i;
  logic [1:0] A1_sel_o, B1_sel_o;
  logic       A2_sel_o, B2_sel_o, BrUn_o, ex_valid_o, redirect_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o),
    .iss_rs1_i(iss_rs1_i), .iss_rs2_i(iss_rs2_i),
    .iss_use_rs1_i(iss_use_rs1_i), .iss_use_rs2_i(iss_use_rs2_i),
    .iss_rd_i(iss_rd_i), .iss_we_i(iss_we_i), .iss_load_i(iss_load_i),
    .iss_branch_i(iss_branch_i), .iss_jump_i(iss_jump_i),
    .iss_funct3_i(iss_funct3_i), .iss_a_pc_i(iss_a_pc_i), .iss_b_imm_i(iss_b_imm_i),
    .BrEq_i(BrEq_i), .BrLT_i(BrLT_i),
    .A1_sel_o(A1_sel_o), .B1_sel_o(B1_sel_o),
    .A2_sel_o(A2_sel_o), .B2_sel_o(B2_sel_o), .BrUn_o(BrUn_o),
    .ex_valid_o(ex_valid_o),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .redirect_o(redirect_o)
  );

  // Inputs change 1 time unit after the rising edge; checks follow at least 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid_i = 0; iss_rs1_i = 0; iss_rs2_i = 0; iss_use_rs1_i = 0; iss_use_rs2_i = 0;
    iss_rd_i = 0; iss_we_i = 0; iss_load_i = 0; iss_branch_i = 0; iss_jump_i = 0;
    iss_funct3_i = 0; iss_a_pc_i = 0; iss_b_imm_i = 0; BrEq_i = 0; BrLT_i = 0;
  endtask

  // ALU-style instruction: rd <= f(rs1, rs2); pass 0 to leave a source unused.
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic imm);
    idle();
    iss_valid_i = 1; iss_rd_i = rd; iss_we_i = 1; iss_b_imm_i = imm;
    iss_rs1_i = rs1; iss_use_rs1_i = 1;
    iss_rs2_i = rs2; iss_use_rs2_i = ~imm;
  endtask

  task automatic flush_pipe();
    idle(); tick(); tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #2;
    tests++; if (ex_valid_o !== 1'b0) begin fails++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid_o); end
    tests++; if ({A1_sel_o, B1_sel_o, A2_sel_o, B2_sel_o, BrUn_o} !== 7'b0) begin fails++;
      $display("FAIL reset_selects got %b exp 0", {A1_sel_o, B1_sel_o, A2_sel_o, B2_sel_o, BrUn_o}); end
    tests++; if (iss_ready_o !== 1'b1 || redirect_o !== 1'b0) begin fails++;
      $display("FAIL reset_ready_redirect got %b%b exp 10", iss_ready_o, redirect_o); end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_alu_fwd();
    flush_pipe();
    alu(5'd5, 5'd1, 5'd2, 0);                       // add x5,x1,x2
    tick();
    tests++; if (ex_valid_o !== 1'b1 || A1_sel_o !== 2'b00 || B1_sel_o !== 2'b00) begin fails++;
      $display("FAIL add_in_stage got v=%b a1=%b b1=%b exp 1/00/00", ex_valid_o, A1_sel_o, B1_sel_o); end
    alu(5'd6, 5'd5, 5'd3, 0);                       // sub x6,x5,x3
    #1;
    tests++; if (iss_ready_o !== 1'b1) begin fails++; $display("FAIL alu_dep_ready got %b exp 1", iss_ready_o); end
    tick();
    tests++; if (ex_valid_o !== 1'b1 || A1_sel_o !== 2'b01 || B1_sel_o !== 2'b00) begin fails++;
      $display("FAIL alu_fwd got v=%b a1=%b b1=%b exp 1/01/00", ex_valid_o, A1_sel_o, B1_sel_o); end
  endtask

  task automatic test_wb_fwd();
    flush_pipe();
    alu(5'd5, 5'd1, 5'd2, 0); tick();
    alu(5'd10, 5'd11, 5'd12, 0); tick();
    alu(5'd7, 5'd4, 5'd5, 0); tick();                // or x7,x4,x5
    tests++; if (A1_sel_o !== 2'b00 || B1_sel_o !== 2'b10) begin fails++;
      $display("FAIL wb_fwd got a1=%b b1=%b exp 00/10", A1_sel_o, B1_sel_o); end
    alu(5'd5, 5'd1, 5'd2, 0); tick();
    alu(5'd5, 5'd3, 5'd4, 0); tick();
    alu(5'd7, 5'd5, 5'd5, 0); tick();
    tests++; if (A1_sel_o !== 2'b01 || B1_sel_o !== 2'b01) begin fails++;
      $display("FAIL ex_priority got a1=%b b1=%b exp 01/01", A1_sel_o, B1_sel_o); end
  endtask

  task automatic test_load_use();
    flush_pipe();
    alu(5'd8, 5'd1, 5'd0, 1); iss_load_i = 1; tick();  // lw x8,0(x1)
    alu(5'd9, 5'd8, 5'd0, 1);                          // addi x9,x8,4
    #1;
    tests++; if (iss_ready_o !== 1'b0) begin fails++; $display("FAIL load_use_stall got %b exp 0", iss_ready_o); end
    tick();
    tests++; if (ex_valid_o !== 1'b0 || B2_sel_o !== 1'b0) begin fails++;
      $display("FAIL load_use_bubble got v=%b b2=%b exp 0/0", ex_valid_o, B2_sel_o); end
    tests++; if (iss_ready_o !== 1'b1) begin fails++; $display("FAIL load_use_release got %b exp 1", iss_ready_o); end
    tick();
    tests++; if (ex_valid_o !== 1'b1 || A1_sel_o !== 2'b10 || B2_sel_o !== 1'b1 || B1_sel_o !== 2'b00) begin fails++;
      $display("FAIL load_use_fwd got v=%b a1=%b b1=%b b2=%b exp 1/10/00/1", ex_valid_o, A1_sel_o, B1_sel_o, B2_sel_o); end
  endtask

  task automatic test_branch();
    flush_pipe();
    idle(); iss_valid_i = 1; iss_branch_i = 1; iss_funct3_i = 3'b110;   // bltu x1,x2
    iss_rs1_i = 1; iss_use_rs1_i = 1; iss_rs2_i = 2; iss_use_rs2_i = 1;
    tick();
    tests++; if (BrUn_o !== 1'b1 || ex_valid_o !== 1'b1) begin fails++;
      $display("FAIL bltu_brun got brun=%b v=%b exp 1/1", BrUn_o, ex_valid_o); end
    alu(5'd20, 5'd21, 5'd22, 0); BrLT_i = 1;
    #1;
    tests++; if (redirect_o !== 1'b1 || iss_ready_o !== 1'b1) begin fails++;
      $display("FAIL bltu_taken got redir=%b rdy=%b exp 1/1", redirect_o, iss_ready_o); end
    tick();
    tests++; if (ex_valid_o !== 1'b0 || redirect_o !== 1'b0) begin fails++;
      $display("FAIL bltu_flush got v=%b redir=%b exp 0/0", ex_valid_o, redirect_o); end
    idle(); iss_valid_i = 1; iss_branch_i = 1; iss_funct3_i = 3'b110;
    tick();
    alu(5'd20, 5'd21, 5'd22, 0); BrLT_i = 0;
    #1;
    tests++; if (redirect_o !== 1'b0) begin fails++; $display("FAIL bltu_not_taken got %b exp 0", redirect_o); end
    tick();
    tests++; if (ex_valid_o !== 1'b1) begin fails++; $display("FAIL bltu_fallthru got %b exp 1", ex_valid_o); end
    idle(); iss_valid_i = 1; iss_branch_i = 1; iss_funct3_i = 3'b101;   // bge
    tick();
    tests++; if (BrUn_o !== 1'b0) begin fails++; $display("FAIL bge_brun got %b exp 0", BrUn_o); end
    idle(); BrLT_i = 0;
    #1;
    tests++; if (redirect_o !== 1'b1) begin fails++; $display("FAIL bge_taken got %b exp 1", redirect_o); end
    idle(); iss_valid_i = 1; iss_branch_i = 1; iss_funct3_i = 3'b010;   // reserved code
    tick(); tick();
    BrEq_i = 1; BrLT_i = 1; iss_valid_i = 0;
    idle(); iss_valid_i = 1; iss_branch_i = 1; iss_funct3_i = 3'b000;   // beq
    tick();
    idle(); BrEq_i = 1;
    #1;
    tests++; if (redirect_o !== 1'b1) begin fails++; $display("FAIL beq_taken got %b exp 1", redirect_o); end
    tick();
    idle(); iss_valid_i = 1; iss_jump_i = 1; iss_we_i = 1; iss_rd_i = 1;  // jal x1
    tick();
    idle();
    #1;
    tests++; if (redirect_o !== 1'b1) begin fails++; $display("FAIL jal_taken got %b exp 1", redirect_o); end
    tick();
    idle(); iss_valid_i = 1; iss_branch_i = 1; iss_funct3_i = 3'b011;   // reserved code
    tick();
    idle(); BrEq_i = 1; BrLT_i = 1;
    #1;
    tests++; if (redirect_o !== 1'b0) begin fails++; $display("FAIL reserved_f3 got %b exp 0", redirect_o); end
    idle();
  endtask

  task automatic test_x0_and_priority();
    flush_pipe();
    alu(5'd0, 5'd1, 5'd0, 1); iss_load_i = 1; tick();    // lw x0
    alu(5'd9, 5'd0, 5'd0, 0);
    #1;
    tests++; if (iss_ready_o !== 1'b1) begin fails++; $display("FAIL x0_no_stall got %b exp 1", iss_ready_o); end
    tick();
    tests++; if (ex_valid_o !== 1'b1 || A1_sel_o !== 2'b00 || B1_sel_o !== 2'b00) begin fails++;
      $display("FAIL x0_selects got v=%b a1=%b b1=%b exp 1/00/00", ex_valid_o, A1_sel_o, B1_sel_o); end
    flush_pipe();
    alu(5'd8, 5'd1, 5'd0, 1); iss_load_i = 1; iss_jump_i = 1; tick();  // load that also redirects
    alu(5'd9, 5'd8, 5'd0, 1);
    #1;
    tests++; if (iss_ready_o !== 1'b1 || redirect_o !== 1'b1) begin fails++;
      $display("FAIL redirect_over_stall got rdy=%b redir=%b exp 1/1", iss_ready_o, redirect_o); end
    tick();
    tests++; if (ex_valid_o !== 1'b0) begin fails++; $display("FAIL redirect_drop got %b exp 0", ex_valid_o); end
  endtask

  task automatic test_reset_mid();
    flush_pipe();
    alu(5'd8, 5'd1, 5'd0, 1); iss_load_i = 1; iss_a_pc_i = 1; tick();
    alu(5'd9, 5'd8, 5'd0, 1);
    #1;
    rst = 1;
    #1;
    tests++; if (ex_valid_o !== 1'b0 || A2_sel_o !== 1'b0 || B2_sel_o !== 1'b0 || redirect_o !== 1'b0) begin fails++;
      $display("FAIL reset_mid got v=%b a2=%b b2=%b redir=%b exp 0/0/0/0", ex_valid_o, A2_sel_o, B2_sel_o, redirect_o); end
    tests++; if (iss_ready_o !== 1'b1) begin fails++; $display("FAIL reset_mid_ready got %b exp 1", iss_ready_o); end
`ifdef HAZARD_PERF_CNT_EN
    tests++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin fails++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt_o, flush_cnt_o); end
`endif
    idle();
    tick();
    rst = 0;
    tick();
    alu(5'd8, 5'd1, 5'd0, 1); iss_load_i = 1; tick();
    alu(5'd9, 5'd8, 5'd0, 1); tick(); tick();
    idle(); tick();
`ifdef HAZARD_PERF_CNT_EN
    tests++; if (stall_cnt_o !== 32'd1 || flush_cnt_o !== 32'd0) begin fails++;
      $display("FAIL cnt_one_stall got %0d/%0d exp 1/0", stall_cnt_o, flush_cnt_o); end
`endif
    tests++; if (ex_valid_o !== 1'b0) begin fails++; $display("FAIL post_reset_drain got %b exp 0", ex_valid_o); end
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    test_reset();
    test_alu_fwd();
    test_wb_fwd();
    test_load_use();
    test_branch();
    test_x0_and_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline control block that sequences the operand-forwarding/branch-compare stage in front of the ALU and data memory. It tracks the two in-flight instructions ahead of the issue point, registers the forwarding and operand-mux selects for the instruction entering the stage, inserts a one-cycle bubble on load-use hazards, and resolves branches/jumps from the stage's compare flags into a redirect/flush request.

## Interface
- No parameters.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `iss_valid_i` in 1: decoded instruction offered for issue.
- `iss_ready_o` out 1: issue accepted this cycle; low = load-use stall.
- `iss_rs1_i`, `iss_rs2_i` in 5 each: source register indices.
- `iss_use_rs1_i`, `iss_use_rs2_i` in 1 each: source actually read.
- `iss_rd_i` in 5: destination index.
- `iss_we_i` in 1: writes `rd`.
- `iss_load_i` in 1: instruction is a load.
- `iss_branch_i` / `iss_jump_i` in 1 each: conditional branch / JAL-JALR.
- `iss_funct3_i` in 3: branch condition code.
- `iss_a_pc_i` / `iss_b_imm_i` in 1 each: ALU operand A = PC / operand B = immediate.
- `BrEq_i`, `BrLT_i` in 1 each: compare flags from the forwarding stage (combinational, same cycle).
- `A1_sel_o`, `B1_sel_o` out 2 each: forward select (00 regfile, 01 ALU result, 10 writeback).
- `A2_sel_o`, `B2_sel_o` out 1 each: PC / immediate select.
- `BrUn_o` out 1: unsigned compare.
- `ex_valid_o` out 1: stage holds a real instruction (0 = bubble).
- `redirect_o` out 1: taken branch/jump in stage; fetch redirects, issue flushed.

## Operation
- State: slot EX (instruction now in the forwarding/ALU stage) and slot M (one ahead; its result is on the ALU-result input, previous M on writeback input). Slot fields: valid, rd, we, load, branch, jump, funct3.
- Each cycle: M <= EX; EX <= accepted issue instruction, else bubble (valid=0).
- Hazard match on EX/M: slot valid & we & rd != 0 & source used & index equal. `x0` never forwarded nor stalled.
- Load-use stall: iss_valid_i & match against EX with EX.load → `iss_ready_o`=0, EX <= bubble.
- `redirect_o` = ex_valid & (EX.jump | EX.branch & cond). cond per funct3: 000 Eq, 001 !Eq, 100/110 LT, 101/111 !LT; 010/011 → not taken.
- When `redirect_o`=1: offered instruction consumed and dropped (`iss_ready_o`=1, EX <= bubble); redirect has priority over stall.
- Select computation for accepted instruction, per source: match EX → 01; else match M → 10; else 00 (EX has priority, youngest wins). Unused source → 00.
- `A2_sel_o`=iss_a_pc_i, `B2_sel_o`=iss_b_imm_i, `BrUn_o`=funct3[1] & branch, all registered with EX. Bubble → all selects 0.

## Timing
- Reset: slots invalid; all select outputs 0; `ex_valid_o`, `redirect_o` 0; `iss_ready_o` reflects comb logic on invalid slots (1).
- Selects, `BrUn_o`, `ex_valid_o` registered: valid the cycle after acceptance, the cycle the instruction occupies the stage.
- `iss_ready_o`, `redirect_o` combinational from slots and inputs.
- Load-use costs exactly one bubble; next cycle load is in M, dependent gets select 10.
- Reset mid-operation clears both slots immediately; no redirect survives reset.

## Configuration
- `HAZARD_PERF_CNT_EN`: defined → extra outputs `stall_cnt_o` and `flush_cnt_o` (32 bits each, reset 0, +1 per stall cycle / per redirect cycle, wrap at 2^32). Undefined → ports and counters absent; behaviour otherwise identical.

## Structure
- Package `riscv_ctrl_pkg`: `fwd_sel_e` (FWD_REG=2'b00, FWD_ALU=2'b01, FWD_WB=2'b10), branch funct3 constants, `pipe_slot_t` struct.
- Sub-module `branch_cond`: (funct3, BrEq, BrLT) → taken, purely combinational.

## Test plan
- Issue `add x5,x1,x2` then `sub x6,x5,x3` back-to-back → second instruction in stage with `A1_sel_o`=01, `B1_sel_o`=00, no stall.
- `add x5`, unrelated, then `or x7,x4,x5` → `B1_sel_o`=10; with x5 written in both EX and M, EX wins (01).
- `lw x8` then `addi x9,x8,4` → `iss_ready_o`=0 one cycle, `ex_valid_o`=0 bubble, then `A1_sel_o`=10, `B2_sel_o`=1.
- `bltu` in stage with `BrLT_i`=1 → `BrUn_o`=1, `redirect_o`=1, concurrent issue dropped (next `ex_valid_o`=0); `BrLT_i`=0 → no redirect.
- Writes to x0 followed by reader of x0 → selects 00, no stall; redirect coinciding with load-use → `iss_ready_o`=1, no stall.
- Assert `rst` mid-stream with load in EX → all outputs 0 immediately; with `HAZARD_PERF_CNT_EN`, counters read 0 and count 1 stall after one load-use.
